// File: rtl/regfile_context_engine.sv
`timescale 1ns/1ps
// Save/restore engine: streams registers FIRST_REG..LAST_REG out of, or back into, the 8x8 register file.
// One byte per cycle at full rate; out_ready low or in_valid low stalls the walk in place.
module regfile_context_engine #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save_req,
  input  logic       restore_req,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [2:0] rf_read_addr,
  input  logic [7:0] rf_read_data,
  output logic       rf_write_enable,
  output logic [2:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  localparam logic [2:0] FIRST_IDX = 3'(FIRST_REG);
  localparam logic [2:0] LAST_IDX  = 3'(LAST_REG);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= FIRST_IDX;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    xfer            = 1'b0;
    busy            = (state != IDLE);
    done            = 1'b0;
    rf_read_addr    = 3'd0;
    rf_write_enable = 1'b0;
    rf_write_addr   = 3'd0;
    rf_write_data   = 8'd0;
    out_valid       = 1'b0;
    out_data        = 8'd0;
    in_ready        = 1'b0;

    case (state)
      IDLE: begin
        // save wins when both requests arrive together
        if (save_req) begin
          state_nxt = SAVE;
          idx_nxt   = FIRST_IDX;
        end else if (restore_req) begin
          state_nxt = RESTORE;
          idx_nxt   = FIRST_IDX;
        end
      end
      SAVE: begin
        rf_read_addr = idx;
        out_valid    = 1'b1;
        out_data     = rf_read_data;
        xfer         = out_ready;
      end
      RESTORE: begin
        in_ready = 1'b1;
        xfer     = in_valid;
        if (in_valid) begin
          rf_write_enable = 1'b1;
          rf_write_addr   = idx;
          rf_write_data   = in_data;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // the byte in the abort cycle still moves; only the sequencing stops
    if (state == SAVE || state == RESTORE) begin
      if (xfer && idx != LAST_IDX)
        idx_nxt = idx + 3'd1;
      if (abort)
        state_nxt = IDLE;
      else if (xfer && idx == LAST_IDX)
        state_nxt = DONE;
    end
  end

endmodule
